rsnn_run_controller: RTL and testbench
======================================

# rsnn_run_controller

Sequencer for the recurrent SNN datapath. It streams the 312-bit weight/parameter image serially into the FIPO parameter memory, then runs a fixed-length inference window of NUM_STEPS timesteps by gating the spike-input register and the network enable. During the window it accumulates per-output spike counts. It sits between the host-side pins and the FIPO memory / input register / three-layer network, and drives their enables directly as synchronous, registered signals.

## Interface
- PARAM_BITS, 312: length of the serial parameter image (216 weight bits + 96 neuron-parameter bits).
- NUM_STEPS, 16: timesteps per inference window (1..255).
- OUT_LAT, 1: cycles from rsnn_enable to the first valid net_spikes sample (0..3).
- clk  in  1: clock.
- reset  in  1: reset, asynchronous, active-high.
- start_load  in  1: single-cycle request to (re)load parameters.
- start_run  in  1: single-cycle request to run one inference window.
- bit_valid  in  1: host serial bit valid.
- bit_data  in  1: host serial bit.
- bit_ready  out  1: controller accepts a bit this cycle.
- fipo_enable  out  1: FIPO write enable.
- fipo_data  out  1: FIPO serial data.
- fipo_end_writing  in  1: FIPO full indication.
- spike_reg_enable  out  1: input spike register enable.
- rsnn_enable  out  1: network enable.
- net_spikes  in  3: network output spikes.
- spike_count0/1/2  out  8 each: per-output spike counts for the last window.
- params_valid  out  1: a complete image is loaded.
- busy  out  1: state is LOAD, RUN or DRAIN.
- done  out  1: one-cycle pulse at the end of a window.
- load_err  out  1: sticky; fipo_end_writing was seen before bit PARAM_BITS, or was not seen with it.

## Operation
- States: IDLE, LOAD, READY, RUN, DRAIN, DONE.
- IDLE:
  - start_load → LOAD; the bit counter clears.
  - start_run is ignored.
- LOAD:
  - bit_ready=1.
  - fipo_enable = bit_valid; fipo_data = bit_data (combinational pass-through).
  - A bit is accepted when bit_valid&bit_ready; each accepted bit increments a 9-bit counter.
  - On the accepted bit PARAM_BITS: go to READY, set params_valid.
  - Early fipo_end_writing, or its absence on the last bit: set load_err; still go to READY, but params_valid=0, so the state behaves as IDLE.
  - start_load/start_run in LOAD are ignored.
- READY (params_valid=1):
  - start_run → RUN; the step counter and spike_count0..2 clear.
  - start_load → LOAD; params_valid clears; load_err clears.
  - If start_load and start_run arrive in the same cycle, start_load wins.
- RUN:
  - spike_reg_enable=rsnn_enable=1 for exactly NUM_STEPS cycles, then → DRAIN.
- DRAIN:
  - Enables are 0 for OUT_LAT cycles, then → DONE.
  - With OUT_LAT=0, DRAIN is skipped.
- Counting:
  - net_spikes are sampled in the cycles starting OUT_LAT after entry to RUN, for NUM_STEPS cycles total.
  - spike_countN += net_spikes[N]; counts saturate at 255.
- DONE: done=1 for one cycle, then → READY. Counts hold until the next start_run.
- reset at any time:
  - State returns to IDLE; all outputs go to 0, including counts, params_valid and load_err.
  - A partial load is discarded.

## Timing
- All outputs except bit_ready, fipo_enable and fipo_data are registered. Those three are decoded from the registered state.
- start_run sampled high at edge T: rsnn_enable is high after edge T+1 through edge T+1+NUM_STEPS.
- done is high in cycle T+1+NUM_STEPS+OUT_LAT.
- Load throughput: one bit per cycle. Minimum load time is PARAM_BITS cycles from LOAD entry.
- busy deasserts in the DONE cycle.
- start_* pulses longer than one cycle:
  - A pulse still high when READY is re-entered starts a new operation.
  - The host must drop it before done.

## Structure
- A shared package rsnn_pkg holds:
  - the state enum;
  - the PARAM_BITS default, plus the WEIGHT_BITS=216 and NEURON_PARAM_BITS=96 constants;
  - the 8-bit count width.
- One natural sub-module, rsnn_sat_counter: an 8-bit saturating counter with clear/inc. It is instantiated three times.

## Test plan
- Load 312 bits with bit_valid held high, and fipo_end_writing on bit 312:
  - params_valid=1 after edge 312;
  - fipo_enable pulses exactly 312 times;
  - load_err=0.
- Load with bit_valid toggling 50%, and fipo_end_writing at bit 200:
  - load_err=1, params_valid=0;
  - a subsequent start_run produces no rsnn_enable.
- NUM_STEPS=16, OUT_LAT=1, net_spikes=3'b101 constant:
  - rsnn_enable is high for 16 cycles;
  - counts are 16/0/16;
  - done arrives 18 cycles after start_run.
- NUM_STEPS=255 with net_spikes=3'b111, then a second run:
  - counts are 255 and do not exceed 255;
  - the second run clears the counts before counting again.
- start_load and start_run in the same READY cycle:
  - enters LOAD;
  - no rsnn_enable;
  - params_valid=0.
- reset asserted at bit 100 of a load, and again mid-RUN:
  - all outputs 0 immediately;
  - state IDLE;
  - a fresh full load then succeeds.

Source files
------------

// File: rtl/rsnn_pkg.sv
// Shared types and constants for the recurrent SNN run controller and its counters.
package rsnn_pkg;

  localparam int WEIGHT_BITS       = 216;
  localparam int NEURON_PARAM_BITS = 96;
  localparam int PARAM_BITS_DFLT   = WEIGHT_BITS + NEURON_PARAM_BITS;
  localparam int CNT_W             = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/rsnn_sat_counter.sv
// Saturating event counter; clr has priority over inc and the value sticks at all-ones.
module rsnn_sat_counter
  import rsnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rsnn_run_controller.sv
// Loads the serial parameter image into the FIPO, then runs one NUM_STEPS inference window.
// Enables and status are registered decodes of the FSM; bit_ready/fipo_* are combinational in LOAD.
module rsnn_run_controller
  import rsnn_pkg::*;
#(
  parameter int PARAM_BITS = PARAM_BITS_DFLT,
  parameter int NUM_STEPS  = 16,
  parameter int OUT_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_load,
  input  logic             start_run,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             fipo_enable,
  output logic             fipo_data,
  input  logic             fipo_end_writing,
  output logic             spike_reg_enable,
  output logic             rsnn_enable,
  input  logic [2:0]       net_spikes,
  output logic [CNT_W-1:0] spike_count0,
  output logic [CNT_W-1:0] spike_count1,
  output logic [CNT_W-1:0] spike_count2,
  output logic             params_valid,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  state_t           state_q, state_d;
  logic [8:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       step_q, step_d;
  logic [OUT_LAT:0] run_dly_q, run_dly_d;
  logic             params_valid_q, params_valid_d;
  logic             load_err_q, load_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic in_load, accept, last_bit, load_ok, load_bad, load_go, run_go, sample_en;

  assign in_load  = (state_q == S_LOAD);
  assign accept   = in_load && bit_valid;
  assign last_bit = (bit_cnt_q == 9'(PARAM_BITS - 1));
  // The FIPO must report full on exactly the last accepted bit; any other combination aborts the load.
  assign load_ok  = accept && last_bit && fipo_end_writing;
  assign load_bad = in_load && (fipo_end_writing != (accept && last_bit));
  assign load_go  = (state_d == S_LOAD) && !in_load;
  assign run_go   = (state_q == S_READY) && (state_d == S_RUN);
  // Tap OUT_LAT of the RUN delay line lines the sample window up with the network's output latency.
  assign sample_en = run_dly_q[OUT_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (load_ok || load_bad) state_d = S_READY;
      end
      S_READY: begin
        if (start_load) begin
          state_d = S_LOAD;
        end else if (start_run && params_valid_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (step_q == 8'(NUM_STEPS - 1)) state_d = (OUT_LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (step_q == 8'(OUT_LAT - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    step_d         = step_q;
    params_valid_d = params_valid_q;
    load_err_d     = load_err_q;
    run_dly_d      = '0;
    busy_d         = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done_d         = (state_q == S_DONE);

    if (load_go) begin
      bit_cnt_d = '0;
    end else if (accept) begin
      bit_cnt_d = bit_cnt_q + 9'd1;
    end

    // The step counter times both RUN and DRAIN, restarting on every state change.
    if (state_d != state_q) begin
      step_d = '0;
    end else if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      step_d = step_q + 8'd1;
    end

    if (load_go) begin
      params_valid_d = 1'b0;
      load_err_d     = 1'b0;
    end else begin
      if (load_ok) params_valid_d = 1'b1;
      if (load_bad) load_err_d = 1'b1;
    end

    run_dly_d[0] = (state_q == S_RUN);
    for (int i = 1; i <= OUT_LAT; i++) begin
      run_dly_d[i] = run_dly_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q      <= '0;
      step_q         <= '0;
      run_dly_q      <= '0;
      params_valid_q <= 1'b0;
      load_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      step_q         <= step_d;
      run_dly_q      <= run_dly_d;
      params_valid_q <= params_valid_d;
      load_err_q     <= load_err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bit_ready        = in_load;
  assign fipo_enable      = accept;
  assign fipo_data        = in_load && bit_data;
  assign spike_reg_enable = run_dly_q[0];
  assign rsnn_enable      = run_dly_q[0];
  assign params_valid     = params_valid_q;
  assign load_err         = load_err_q;
  assign busy             = busy_q;
  assign done             = done_q;

  rsnn_sat_counter u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .clr   (run_go),
    .inc   (sample_en && net_spikes[0]),
    .cnt   (spike_count0)
  );

  rsnn_sat_counter u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .clr   (run_go),
    .inc   (sample_en && net_spikes[1]),
    .cnt   (spike_count1)
  );

  rsnn_sat_counter u_cnt2 (
    .clk   (clk),
    .reset (reset),
    .clr   (run_go),
    .inc   (sample_en && net_spikes[2]),
    .cnt   (spike_count2)
  );

endmodule

// File: tb/tb_rsnn_run_controller.sv
// Bench for rsnn_run_controller: one instance with a 16-step window / latency 1, one with 255 steps / latency 0.
module tb_rsnn_run_controller;
  import rsnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_load, start_run_a, start_run_b;
  logic       bit_valid, bit_data, fipo_end_writing;
  logic [2:0] net_spikes;

  logic       bit_ready_a, fipo_enable_a, fipo_data_a, spike_reg_enable_a, rsnn_enable_a;
  logic       params_valid_a, busy_a, done_a, load_err_a;
  logic [7:0] cnt0_a, cnt1_a, cnt2_a;
  logic       bit_ready_b, fipo_enable_b, fipo_data_b, spike_reg_enable_b, rsnn_enable_b;
  logic       params_valid_b, busy_b, done_b, load_err_b;
  logic [7:0] cnt0_b, cnt1_b, cnt2_b;
  logic [32:0] outs_a, outs_b;

  int errors = 0;
  int checks = 0;

  assign outs_a = {bit_ready_a, fipo_enable_a, fipo_data_a, spike_reg_enable_a, rsnn_enable_a,
                   cnt0_a, cnt1_a, cnt2_a, params_valid_a, busy_a, done_a, load_err_a};
  assign outs_b = {bit_ready_b, fipo_enable_b, fipo_data_b, spike_reg_enable_b, rsnn_enable_b,
                   cnt0_b, cnt1_b, cnt2_b, params_valid_b, busy_b, done_b, load_err_b};

  rsnn_run_controller #(.PARAM_BITS(312), .NUM_STEPS(16), .OUT_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start_load(start_load), .start_run(start_run_a),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready_a),
    .fipo_enable(fipo_enable_a), .fipo_data(fipo_data_a), .fipo_end_writing(fipo_end_writing),
    .spike_reg_enable(spike_reg_enable_a), .rsnn_enable(rsnn_enable_a), .net_spikes(net_spikes),
    .spike_count0(cnt0_a), .spike_count1(cnt1_a), .spike_count2(cnt2_a),
    .params_valid(params_valid_a), .busy(busy_a), .done(done_a), .load_err(load_err_a)
  );

  rsnn_run_controller #(.PARAM_BITS(312), .NUM_STEPS(255), .OUT_LAT(0)) dut_b (
    .clk(clk), .reset(reset), .start_load(start_load), .start_run(start_run_b),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready_b),
    .fipo_enable(fipo_enable_b), .fipo_data(fipo_data_b), .fipo_end_writing(fipo_end_writing),
    .spike_reg_enable(spike_reg_enable_b), .rsnn_enable(rsnn_enable_b), .net_spikes(net_spikes),
    .spike_count0(cnt0_b), .spike_count1(cnt1_b), .spike_count2(cnt2_b),
    .params_valid(params_valid_b), .busy(busy_b), .done(done_b), .load_err(load_err_b)
  );

  // Streams n_bits host bits after a start_load pulse; fipo_end_writing accompanies bit number end_at.
  task automatic load_bits(input int n_bits, input int end_at, input bit toggle,
                           output int pulses, output int data_bad);
    int   j;
    int   guard;
    logic v;
    j = 0;
    guard = 0;
    pulses = 0;
    data_bad = 0;
    @(posedge clk); #1;
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    while ((j < n_bits) && (guard < 4000)) begin
      guard++;
      v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_valid = v;
      bit_data  = 1'($urandom_range(0, 1));
      if (v) j++;
      fipo_end_writing = v && (j == end_at);
      @(negedge clk);
      if (fipo_enable_a === 1'b1) pulses++;
      if ((fipo_enable_a === 1'b1) && (fipo_data_a !== bit_data)) data_bad++;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    fipo_end_writing = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (outs_a !== 33'd0) begin
      errors++;
      $display("FAIL %s outputs_a: got %h expected 0", name, outs_a);
    end
    checks++;
    if (outs_b !== 33'd0) begin
      errors++;
      $display("FAIL %s outputs_b: got %h expected 0", name, outs_b);
    end
    start_load = 1'b0; start_run_a = 1'b0; start_run_b = 1'b0;
    bit_valid = 1'b0; bit_data = 1'b0; fipo_end_writing = 1'b0; net_spikes = 3'd0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs one window on the selected instance and compares against a window-sum model of net_spikes.
  task automatic run_window(input bit sel_b, input bit rnd, input logic [2:0] fixed, input string name);
    int         ns, ol, n_cyc, en_cnt, en_bad, sre_bad, done_cnt, done_k;
    int         exp_c[3];
    int         got_c[3];
    logic       en, sre, dn, bz, busy_at_done, busy_k1;
    logic [2:0] v;
    logic [2:0] hist[$];
    ns = sel_b ? 255 : 16;
    ol = sel_b ? 0 : 1;
    n_cyc = ns + ol + 5;
    en_cnt = 0; en_bad = 0; sre_bad = 0; done_cnt = 0; done_k = -1;
    busy_at_done = 1'bx; busy_k1 = 1'bx;
    @(posedge clk); #1;
    if (sel_b) start_run_b = 1'b1; else start_run_a = 1'b1;
    net_spikes = rnd ? 3'($urandom_range(0, 7)) : fixed;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk); #1;
      start_run_a = 1'b0;
      start_run_b = 1'b0;
      v = rnd ? 3'($urandom_range(0, 7)) : fixed;
      net_spikes = v;
      hist.push_back(v);
      @(negedge clk);
      en  = sel_b ? rsnn_enable_b : rsnn_enable_a;
      sre = sel_b ? spike_reg_enable_b : spike_reg_enable_a;
      dn  = sel_b ? done_b : done_a;
      bz  = sel_b ? busy_b : busy_a;
      if (en === 1'b1) en_cnt++;
      if (en !== ((k >= 1) && (k <= ns))) en_bad++;
      if (sre !== ((k >= 1) && (k <= ns))) sre_bad++;
      if (k == 1) busy_k1 = bz;
      if (dn === 1'b1) begin
        done_cnt++;
        done_k = k;
        busy_at_done = bz;
      end
    end
    net_spikes = 3'd0;
    for (int n = 0; n < 3; n++) begin
      exp_c[n] = 0;
      for (int k = ol + 1; k <= ns + ol; k++) begin
        v = hist[k];
        exp_c[n] += int'(v[n]);
      end
      if (exp_c[n] > 255) exp_c[n] = 255;
    end
    got_c[0] = int'(sel_b ? cnt0_b : cnt0_a);
    got_c[1] = int'(sel_b ? cnt1_b : cnt1_a);
    got_c[2] = int'(sel_b ? cnt2_b : cnt2_a);
    checks++;
    if (en_cnt !== ns) begin
      errors++;
      $display("FAIL %s rsnn_enable_cycles: got %0d expected %0d", name, en_cnt, ns);
    end
    checks++;
    if (en_bad !== 0) begin
      errors++;
      $display("FAIL %s rsnn_enable_window: got %0d misplaced cycles expected 0", name, en_bad);
    end
    checks++;
    if (sre_bad !== 0) begin
      errors++;
      $display("FAIL %s spike_reg_enable_window: got %0d misplaced cycles expected 0", name, sre_bad);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_k !== ns + ol + 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d expected %0d", name, done_k, ns + ol + 1);
    end
    checks++;
    if (busy_k1 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_run: got %b expected 1", name, busy_k1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy_at_done);
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (got_c[n] !== exp_c[n]) begin
        errors++;
        $display("FAIL %s spike_count%0d: got %0d expected %0d", name, n, got_c[n], exp_c[n]);
      end
    end
  endtask

  task automatic test_reset;
    int en_seen;
    reset = 1'b1;
    start_load = 1'b0; start_run_a = 1'b0; start_run_b = 1'b0;
    bit_valid = 1'b0; bit_data = 1'b0; fipo_end_writing = 1'b0; net_spikes = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs_a !== 33'd0) begin
      errors++;
      $display("FAIL reset_state_a: got %h expected 0", outs_a);
    end
    checks++;
    if (outs_b !== 33'd0) begin
      errors++;
      $display("FAIL reset_state_b: got %h expected 0", outs_b);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start_run_a = 1'b1;
    start_run_b = 1'b1;
    @(posedge clk); #1;
    start_run_a = 1'b0;
    start_run_b = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((rsnn_enable_a === 1'b1) || (rsnn_enable_b === 1'b1) || (busy_a === 1'b1)) en_seen++;
    end
    checks++;
    if (en_seen !== 0) begin
      errors++;
      $display("FAIL idle_ignores_start_run: got %0d active cycles expected 0", en_seen);
    end
  endtask

  task automatic test_load_good;
    int pulses, dbad;
    load_bits(312, 312, 1'b0, pulses, dbad);
    bit_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (pulses !== 312) begin
      errors++;
      $display("FAIL load_good fipo_enable_pulses: got %0d expected 312", pulses);
    end
    checks++;
    if (dbad !== 0) begin
      errors++;
      $display("FAIL load_good fipo_data: got %0d wrong bits expected 0", dbad);
    end
    checks++;
    if (fipo_enable_a !== 1'b0) begin
      errors++;
      $display("FAIL load_good extra_bit_refused: got %b expected 0", fipo_enable_a);
    end
    checks++;
    if (params_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL load_good params_valid_a: got %b expected 1", params_valid_a);
    end
    checks++;
    if (load_err_a !== 1'b0) begin
      errors++;
      $display("FAIL load_good load_err_a: got %b expected 0", load_err_a);
    end
    checks++;
    if (params_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL load_good params_valid_b: got %b expected 1", params_valid_b);
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_load_run_same_cycle;
    int en_seen;
    @(posedge clk); #1;
    start_load = 1'b1;
    start_run_a = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    start_run_a = 1'b0;
    @(negedge clk);
    checks++;
    if (bit_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle enters_load: got bit_ready %b expected 1", bit_ready_a);
    end
    checks++;
    if (params_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle params_valid: got %b expected 0", params_valid_a);
    end
    en_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsnn_enable_a === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen !== 0) begin
      errors++;
      $display("FAIL same_cycle rsnn_enable: got %0d cycles expected 0", en_seen);
    end
    do_reset("same_cycle_cleanup");
  endtask

  task automatic test_load_error;
    int pulses, dbad, act;
    load_bits(200, 200, 1'b1, pulses, dbad);
    @(negedge clk);
    checks++;
    if (pulses !== 200) begin
      errors++;
      $display("FAIL load_err fipo_enable_pulses: got %0d expected 200", pulses);
    end
    checks++;
    if (load_err_a !== 1'b1) begin
      errors++;
      $display("FAIL load_err flag: got %b expected 1", load_err_a);
    end
    checks++;
    if (params_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL load_err params_valid: got %b expected 0", params_valid_a);
    end
    checks++;
    if (bit_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL load_err load_aborted: got bit_ready %b expected 0", bit_ready_a);
    end
    @(posedge clk); #1;
    start_run_a = 1'b1;
    @(posedge clk); #1;
    start_run_a = 1'b0;
    act = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if ((rsnn_enable_a === 1'b1) || (done_a === 1'b1)) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL load_err run_blocked: got %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_reset_recovery;
    int pulses, dbad;
    load_bits(100, 0, 1'b0, pulses, dbad);
    do_reset("reset_mid_load");
    bit_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bit_ready_a, fipo_enable_a, busy_a, params_valid_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_load idle_after: got %b expected 0000",
               {bit_ready_a, fipo_enable_a, busy_a, params_valid_a});
    end
    bit_valid = 1'b0;
    load_bits(312, 312, 1'b0, pulses, dbad);
    @(negedge clk);
    checks++;
    if (params_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_partial params_valid: got %b expected 1", params_valid_a);
    end
    @(posedge clk); #1;
    start_run_a = 1'b1;
    net_spikes = 3'b111;
    @(posedge clk); #1;
    start_run_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_reset("reset_mid_run");
    load_bits(312, 312, 1'b0, pulses, dbad);
    @(negedge clk);
    checks++;
    if (pulses !== 312) begin
      errors++;
      $display("FAIL reload_after_run fipo_enable_pulses: got %0d expected 312", pulses);
    end
    checks++;
    if ({params_valid_a, load_err_a} !== 2'b10) begin
      errors++;
      $display("FAIL reload_after_run status: got %b expected 10", {params_valid_a, load_err_a});
    end
    run_window(1'b0, 1'b1, 3'b000, "run_after_reset");
  endtask

  initial begin
    test_reset();
    test_load_good();
    run_window(1'b0, 1'b0, 3'b101, "run_fixed_101");
    run_window(1'b0, 1'b1, 3'b000, "run_random_a");
    run_window(1'b1, 1'b0, 3'b111, "run_saturate_b");
    run_window(1'b1, 1'b1, 3'b000, "run_second_b");
    test_load_run_same_cycle();
    test_load_error();
    test_reset_recovery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
